// File: rtl/fme_pkg.sv
// Shared types and width helpers for the fractional-ME cost sequencer.
package fme_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CMP  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Lambda-weighted cost headroom: DATAWIDTH plus 9 bits never overflows.
  function automatic int unsigned cost_w(input int unsigned dw);
    return dw + 9;
  endfunction

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fme_cost_sequencer_if.sv
// Handshake and result bundle between the SAD row pipeline, accumulator and sequencer.
interface fme_cost_sequencer_if #(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned NUM_CAND  = 9
) ();
  localparam int unsigned CW   = fme_pkg::cost_w(DATAWIDTH);
  localparam int unsigned IDXW = fme_pkg::idx_w(NUM_CAND);

  logic            start;
  logic            row_valid;
  logic            row_ready;
  logic [CW-1:0]   acc_out;
  logic            acc_enable;
  logic            acc_sel;
  logic            busy;
  logic            done;
  logic [CW-1:0]   best_cost;
  logic [IDXW-1:0] best_idx;

  modport master (
    output start, row_valid, acc_out,
    input  row_ready, acc_enable, acc_sel, busy, done, best_cost, best_idx
  );

  modport slave (
    input  start, row_valid, acc_out,
    output row_ready, acc_enable, acc_sel, busy, done, best_cost, best_idx
  );
endinterface

// File: rtl/fme_cost_sequencer_tracker.sv
// Running-minimum register: first candidate loads unconditionally, later ones replace on strictly lower cost.
module cost_min_tracker #(
  parameter int unsigned CW   = 17,
  parameter int unsigned IDXW = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load_i,
  input  logic            update_i,
  input  logic [CW-1:0]   cost_i,
  input  logic [IDXW-1:0] idx_i,
  output logic [CW-1:0]   best_cost_o,
  output logic [IDXW-1:0] best_idx_o
);
  logic [CW-1:0]   best_cost_q, best_cost_d;
  logic [IDXW-1:0] best_idx_q, best_idx_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      best_cost_q <= '0;
      best_idx_q  <= '0;
    end else begin
      best_cost_q <= best_cost_d;
      best_idx_q  <= best_idx_d;
    end
  end

  // Strict less-than keeps the lower index on ties.
  always_comb begin
    best_cost_d = best_cost_q;
    best_idx_d  = best_idx_q;
    if (load_i) begin
      best_cost_d = cost_i;
      best_idx_d  = idx_i;
    end else if (update_i && (cost_i < best_cost_q)) begin
      best_cost_d = cost_i;
      best_idx_d  = idx_i;
    end
  end

  assign best_cost_o = best_cost_q;
  assign best_idx_o  = best_idx_q;
endmodule

// File: rtl/fme_cost_sequencer.sv
// Steps the external cost accumulator through ROWS beats per candidate and tracks the cheapest of NUM_CAND.
module fme_cost_sequencer
  import fme_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned ROWS      = 4,
  parameter int unsigned NUM_CAND  = 9
) (
  input logic                 clock,
  input logic                 reset,
  fme_cost_sequencer_if.slave bus
);
  localparam int unsigned CW   = cost_w(DATAWIDTH);
  localparam int unsigned IDXW = idx_w(NUM_CAND);
  localparam int unsigned ROWW = $clog2(ROWS);

  state_e          state_q, state_d;
  logic [ROWW-1:0] row_q, row_d;
  logic [IDXW-1:0] cand_q, cand_d;

  logic            row_ready;
  logic            acc_enable;
  logic            acc_sel;
  logic            load;
  logic            update;
  logic [CW-1:0]   best_cost;
  logic [IDXW-1:0] best_idx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      cand_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cand_q  <= cand_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    cand_d     = cand_q;
    row_ready  = 1'b0;
    acc_enable = 1'b0;
    acc_sel    = 1'b0;
    load       = 1'b0;
    update     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          row_d   = '0;
          cand_d  = '0;
        end
      end
      RUN: begin
        row_ready = 1'b1;
        if (bus.row_valid) begin
          acc_enable = 1'b1;
          // First beat of a candidate reloads lambda; the rest accumulate.
          acc_sel    = (row_q != '0);
          if (row_q == ROWW'(ROWS - 1)) begin
            row_d   = '0;
            state_d = CMP;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      CMP: begin
        load   = (cand_q == '0);
        update = (cand_q != '0);
        if (cand_q == IDXW'(NUM_CAND - 1)) begin
          state_d = DONE;
        end else begin
          cand_d  = cand_q + 1'b1;
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  cost_min_tracker #(
    .CW   (CW),
    .IDXW (IDXW)
  ) u_tracker (
    .clock       (clock),
    .reset       (reset),
    .load_i      (load),
    .update_i    (update),
    .cost_i      (bus.acc_out),
    .idx_i       (cand_q),
    .best_cost_o (best_cost),
    .best_idx_o  (best_idx)
  );

  assign bus.row_ready  = row_ready;
  assign bus.acc_enable = acc_enable;
  assign bus.acc_sel    = acc_sel;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);
  assign bus.best_cost  = best_cost;
  assign bus.best_idx   = best_idx;
endmodule

// File: tb/tb_fme_cost_sequencer.sv
// Scoreboard bench: randomized searches through a lambda accumulator model, results checked against a minimum-of-costs reference.
module tb_fme_cost_sequencer;
  import fme_pkg::*;

  localparam int unsigned DW     = 8;
  localparam int unsigned ROWS   = 4;
  localparam int unsigned NC     = 9;
  localparam int unsigned CW     = cost_w(DW);
  localparam int unsigned LAMBDA = 10;
  localparam int          LAT    = NC * (ROWS + 1) + 1;

  typedef int unsigned cvec_t [NC];
  typedef struct {
    longint cost;
    longint idx;
    int     lat;
    int     t0;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  fme_cost_sequencer_if #(.DATAWIDTH(DW), .NUM_CAND(NC)) bus ();
  fme_cost_sequencer #(.DATAWIDTH(DW), .ROWS(ROWS), .NUM_CAND(NC)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  fme_cost_sequencer_if #(.DATAWIDTH(DW), .NUM_CAND(1)) sbus ();
  fme_cost_sequencer #(.DATAWIDTH(DW), .ROWS(2), .NUM_CAND(1)) dut_small (
    .clock (clock),
    .reset (reset),
    .bus   (sbus)
  );

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int done_cnt = 0;
  exp_t sb[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
  endtask

  // Accumulator model: sel=0 loads lambda+in, sel=1 adds in; registered output.
  logic [CW-1:0] acc;
  logic [DW-1:0] beat;
  logic          s_en, s_sel;
  logic [DW-1:0] s_in;
  assign bus.acc_out = acc;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock or posedge reset) begin
    if (reset) acc <= '0;
    else if (s_en) acc <= s_sel ? acc + CW'(s_in) : CW'(LAMBDA) + CW'(s_in);
  end

  // Monitor: samples late in the low phase, after the driver has settled.
  int k = 0;
  always @(negedge clock) begin
    #3;
    if (reset) begin
      k = 0;
      s_en = 1'b0;
      s_sel = 1'b0;
      s_in = '0;
    end else begin
      s_en = bus.acc_enable;
      s_sel = bus.acc_sel;
      s_in = beat;
      if (bus.acc_enable || bus.row_valid)
        chk("acc_enable_vs_accept", longint'(bus.acc_enable), longint'(bus.row_valid && bus.row_ready));
      if (bus.acc_enable) begin
        chk("acc_sel", longint'(bus.acc_sel), longint'(k != 0));
        k = (k + 1) % ROWS;
      end
      if (bus.done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("best_cost", longint'(bus.best_cost), e.cost);
          chk("best_idx", longint'(bus.best_idx), e.idx);
          if (e.lat != 0) chk("done_latency", longint'(cyc - e.t0), longint'(e.lat));
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!bus.row_ready) begin
      @(negedge clock);
      n++;
      if (n > 200) begin
        $display("FAIL row_ready_timeout: got 0 expected 1 at cycle %0d", cyc);
        $fatal(1, "handshake stuck");
      end
    end
  endtask

  task automatic wait_done_main();
    int n = 0;
    while (!bus.done) begin
      @(negedge clock);
      n++;
      if (n > 500) begin
        $display("FAIL done_timeout: got 0 expected 1 at cycle %0d", cyc);
        $fatal(1, "no done");
      end
    end
  endtask

  // Called at a negedge with the DUT idle. Leaves at the negedge of the cycle after done.
  task automatic run_search(input cvec_t costs, input int stall_pct, input bit chk_lat, input bit poke);
    exp_t e;
    longint best;
    int bi;
    best = costs[0];
    bi = 0;
    for (int i = 1; i < NC; i++)
      if (costs[i] < best) begin
        best = costs[i];
        bi = i;
      end
    e.cost = best;
    e.idx = bi;
    e.lat = chk_lat ? LAT : 0;
    e.t0 = cyc;
    sb.push_back(e);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    for (int c = 0; c < NC; c++) begin
      int rem = int'(costs[c]) - int'(LAMBDA);
      for (int r = 0; r < ROWS; r++) begin
        int left = ROWS - r;
        int lo = rem - 255 * (left - 1);
        int hi = (rem < 255) ? rem : 255;
        int b;
        if (lo < 0) lo = 0;
        b = (left == 1) ? rem : int'($urandom_range(hi, lo));
        rem -= b;
        while (int'($urandom_range(99, 0)) < stall_pct) begin
          bus.row_valid = 1'b0;
          @(negedge clock);
        end
        bus.row_valid = 1'b1;
        beat = DW'(b);
        bus.start = poke && (r == 1);
        wait_ready();
        @(negedge clock);
        bus.start = 1'b0;
      end
    end
    wait_done_main();
    bus.start = poke;
    @(negedge clock);
    bus.start = 1'b0;
    bus.row_valid = 1'b0;
    if (poke) begin
      @(negedge clock);
      chk("start_in_done_ignored", longint'(bus.busy), 0);
    end
  endtask

  task automatic rand_costs(input int unsigned lo, input int unsigned hi, output cvec_t cv);
    for (int i = 0; i < NC; i++) cv[i] = $urandom_range(hi, lo);
  endtask

  initial begin
    cvec_t cv;
    int n;
    int dc;
    bus.start = 1'b0;
    bus.row_valid = 1'b0;
    sbus.start = 1'b0;
    sbus.row_valid = 1'b0;
    sbus.acc_out = '0;
    beat = '0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_row_ready", longint'(bus.row_ready), 0);
    chk("rst_busy", longint'(bus.busy), 0);
    chk("rst_done", longint'(bus.done), 0);
    chk("rst_acc_enable", longint'(bus.acc_enable), 0);
    chk("rst_acc_sel", longint'(bus.acc_sel), 0);
    chk("rst_best_cost", longint'(bus.best_cost), 0);
    chk("rst_best_idx", longint'(bus.best_idx), 0);
    reset = 1'b0;
    @(negedge clock);

    // Abandon a search at cand=3, row=2 (14 accepted beats).
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    bus.row_valid = 1'b1;
    beat = 8'd5;
    n = 0;
    for (int t = 0; t < 100 && n < 14; t++) begin
      if (bus.row_ready) n++;
      @(negedge clock);
    end
    chk("midrun_beats", longint'(n), 14);
    dc = done_cnt;
    reset = 1'b1;
    #1;
    chk("midrst_busy", longint'(bus.busy), 0);
    chk("midrst_row_ready", longint'(bus.row_ready), 0);
    chk("midrst_acc_enable", longint'(bus.acc_enable), 0);
    chk("midrst_best_cost", longint'(bus.best_cost), 0);
    @(negedge clock);
    reset = 1'b0;
    bus.row_valid = 1'b0;
    repeat (10) @(negedge clock);
    chk("no_done_after_abort", longint'(done_cnt), longint'(dc));

    // Reference vector: costs with a tie at 30 between indices 5 and 6.
    cv = '{50, 40, 45, 40, 60, 30, 30, 70, 31};
    run_search(cv, 0, 1'b1, 1'b1);
    repeat (2) @(negedge clock);
    run_search(cv, 50, 1'b0, 1'b0);
    repeat (2) @(negedge clock);

    for (int s = 0; s < 4; s++) begin
      rand_costs(10, 40, cv);
      run_search(cv, 40, 1'b0, (s % 2) == 1);
      repeat (1) @(negedge clock);
    end
    rand_costs(10, 1000, cv);
    run_search(cv, 0, 1'b1, 1'b0);

    // Back-to-back: second search is costlier everywhere yet must replace the old best.
    rand_costs(10, 30, cv);
    run_search(cv, 0, 1'b1, 1'b0);
    rand_costs(500, 600, cv);
    run_search(cv, 0, 1'b1, 1'b0);

    // row_valid held in IDLE must not enable the accumulator.
    bus.row_valid = 1'b1;
    repeat (5) @(negedge clock);
    chk("idle_hold_busy", longint'(bus.busy), 0);
    chk("idle_hold_acc_enable", longint'(bus.acc_enable), 0);
    bus.row_valid = 1'b0;
    @(negedge clock);

    // Single-candidate, two-row instance: 77 then 0 back-to-back.
    for (int p = 0; p < 2; p++) begin
      int t0;
      longint cval;
      cval = (p == 0) ? 77 : 0;
      sbus.acc_out = CW'(cval);
      sbus.row_valid = 1'b1;
      t0 = cyc;
      sbus.start = 1'b1;
      @(negedge clock);
      sbus.start = 1'b0;
      n = 0;
      while (!sbus.done && n < 50) begin
        @(negedge clock);
        n++;
      end
      chk("small_done_seen", longint'(sbus.done), 1);
      chk("small_latency", longint'(cyc - t0), 4);
      chk("small_best_cost", longint'(sbus.best_cost), cval);
      chk("small_best_idx", longint'(sbus.best_idx), 0);
      @(negedge clock);
      sbus.row_valid = 1'b0;
    end

    repeat (3) @(negedge clock);
    chk("scoreboard_drained", longint'(sb.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fme_cost_sequencer.md
# fme_cost_sequencer

Sequences the lambda-weighted cost accumulator during fractional motion estimation. For each of NUM_CAND candidate positions it drives the accumulator's enable/select over ROWS partial-SAD beats, then compares the finished cost against the running best. When all candidates are done it reports the minimum cost and its candidate index. It sits between the SAD row pipeline (upstream, valid/ready) and the mode-decision stage (downstream, done pulse).

## Interface
- DATAWIDTH, 8, pixel width; matches the accumulator's DATAWIDTH.
- ROWS, 4, partial-SAD beats per candidate; minimum 2.
- NUM_CAND, 9, candidates per search (centre + 8 half-pel); minimum 1.
- IDXW, $clog2(NUM_CAND) (minimum 1), candidate index width.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  begin a search; sampled only in IDLE.
- row_valid  in  1  a partial-SAD beat is present at the accumulator's input.
- row_ready  out  1  sequencer accepts a beat; high only in RUN.
- acc_out  in  DATAWIDTH+9  the accumulator's registered output.
- acc_enable  out  1  to the accumulator's enable.
- acc_sel  out  1  to the accumulator's sel. 0 loads lambda_r+in; 1 adds in to out.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; best_cost/best_idx are valid and stable from this cycle.
- best_cost  out  DATAWIDTH+9  minimum accumulated cost.
- best_idx  out  IDXW  candidate index of best_cost.

## Operation
- States: IDLE, RUN, CMP, DONE.
- IDLE: outputs quiescent. start=1 → RUN; row=0, cand=0.
- RUN: row_ready=1. A beat is accepted when row_valid&row_ready.
  - On acceptance: acc_enable=1, acc_sel=(row!=0), row increments.
  - Acceptance with row==ROWS-1 → CMP; row resets to 0.
  - No acceptance: acc_enable=0 and the accumulator holds.
- CMP: acc_out now holds the finished cost; row_ready=0, acc_enable=0.
  - cand==0: best_cost←acc_out, best_idx←0 unconditionally.
  - cand>0: update only if acc_out < best_cost, strictly. Ties keep the lower index.
  - If cand==NUM_CAND-1 → DONE, otherwise cand increments → RUN.
- DONE: done=1 for exactly one cycle → IDLE. best_* hold until the next search's first CMP.
- acc_enable/acc_sel are combinational from state, row and row_valid. They are never asserted outside RUN.
- start while busy: ignored. row_valid outside RUN: ignored; upstream must hold the beat.
- Comparison is unsigned, full DATAWIDTH+9 bits. No saturation; the accumulator width guarantees no overflow.
- reset at any point: state=IDLE, row=0, cand=0, best_cost=0, best_idx=0, done=0, busy=0, acc_enable=0, acc_sel=0. An in-flight search is abandoned with no done pulse.

## Timing
- Reset values: all outputs 0; row_ready=0.
- Per candidate: ROWS accepted beats plus 1 CMP cycle.
- With no stalls, start high at edge 0 gives:
  - first acceptance cycle 1;
  - done at cycle NUM_CAND·(ROWS+1)+1;
  - busy low the following cycle.
- Back-to-back: start may be asserted in the cycle after done (IDLE). The earliest new RUN is 2 cycles after done.
- row_valid may drop mid-candidate. row holds and the sel sequence resumes correctly: the first beat is always sel=0, later beats sel=1.

## Structure
- Shared package fme_pkg holds:
  - state enum (IDLE, RUN, CMP, DONE);
  - cost width function cost_w(DATAWIDTH)=DATAWIDTH+9.
- Sub-module cost_min_tracker holds best_cost/best_idx. Inputs: clear-and-load for the first candidate, strict-less update, index.
- Sequencer top holds the FSM and the row/cand counters.
- The accumulator is instantiated by the parent, not inside this block.

## Test plan
- Reset mid-RUN (cand=3, row=2) → all outputs 0, state IDLE, no done pulse. A subsequent start runs a full clean search.
- ROWS=4, NUM_CAND=9, acc model with lambda_r=10, no stalls:
  - accumulated costs 50,40,45,40,60,30,30,70,31 → done at cycle 46, best_cost=30, best_idx=5 (tie with index 6 resolved to lower).
  - acc_sel pattern per candidate is 0,1,1,1.
- Random row_valid stalls (~50%) on the same data → identical best_cost/best_idx. acc_enable is high only on accepted beats.
- start pulsed during RUN and DONE → ignored. row_valid held high in CMP/IDLE → no acc_enable, beat not consumed.
- NUM_CAND=1, ROWS=2: single candidate with cost 0 → best_cost=0, best_idx=0, done at cycle 4.
- Back-to-back searches: start the cycle after done. Second search's first CMP loads unconditionally even when its cost exceeds the previous best.
